// File: rtl/nios2_pio_in_edge_pkg.sv
// Shared constants for the Nios II input PIO: register map and edge-capture mode encoding.
package nios2_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios2_pio_in_edge_debounce.sv
// Single-bit input conditioner: SYNC_STAGES synchroniser plus optional debounce filter.
// Debounce is built only when PIO_DEBOUNCE_EN is defined; otherwise filt is the synchronised input.
module nios2_pio_debounce
  import nios2_pio_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic filt
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   sync;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("nios2_pio_debounce: parameter out of range");
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain <= {SYNC_STAGES{RESET_VAL}};
    else          chain <= {chain[SYNC_STAGES-2:0], din};
  end

  assign sync = chain[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             filt_q;

  // The toggle fires on the cycle the count would reach DEBOUNCE_CYCLES, so filt
  // follows sync exactly DEBOUNCE_CYCLES cycles after sync first differs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      filt_q <= RESET_VAL;
    end else if (sync == filt_q) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      filt_q <= sync;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync;
`endif

endmodule

// File: rtl/nios2_pio_in_edge.sv
// Avalon-MM input PIO: synchronised inputs, per-bit edge capture (W1C), masked level IRQ.
// Optional per-bit debounce is enabled by defining PIO_DEBOUNCE_EN.
module nios2_pio_in_edge
  import nios2_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter int               EDGE_TYPE       = EDGE_RISING,
  parameter logic [WIDTH-1:0] IN_RESET_VAL    = '0,
  parameter int               DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int PRIME_W = $clog2(SYNC_STAGES + 2);

  logic [WIDTH-1:0]   filt;
  logic [WIDTH-1:0]   prev;
  logic [WIDTH-1:0]   rise;
  logic [WIDTH-1:0]   fall;
  logic [WIDTH-1:0]   edge_sel;
  logic [WIDTH-1:0]   edge_det;
  logic [WIDTH-1:0]   clr;
  logic [WIDTH-1:0]   edgecap;
  logic [WIDTH-1:0]   irqmask;
  logic [PRIME_W-1:0] prime_cnt;
  logic               primed;
  logic               wr_en;
  logic               unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr_en        = chipselect & ~write_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios2_pio_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (IN_RESET_VAL[i])
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .filt    (filt[i])
    );
  end

  always_comb begin
    rise = filt & ~prev;
    fall = ~filt & prev;
    case (EDGE_TYPE)
      EDGE_FALLING: edge_sel = fall;
      EDGE_ANY:     edge_sel = rise | fall;
      default:      edge_sel = rise;
    endcase
    // Edges are ignored until the synchroniser has flushed its reset contents.
    edge_det = primed ? edge_sel : '0;
    clr      = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev      <= IN_RESET_VAL;
      prime_cnt <= '0;
      primed    <= 1'b0;
      edgecap   <= '0;
      irqmask   <= '0;
      irq       <= 1'b0;
      readdata  <= '0;
    end else begin
      prev <= filt;
      if (!primed) begin
        if (prime_cnt == PRIME_W'(SYNC_STAGES)) primed    <= 1'b1;
        else                                    prime_cnt <= prime_cnt + PRIME_W'(1);
      end
      // Set after clear: an edge landing with a W1C of the same bit is kept.
      edgecap <= (edgecap & ~clr) | edge_det;
      if (wr_en && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
      irq <= |(edgecap & irqmask);
      case (address)
        ADDR_DATA:    readdata <= 32'(filt);
        ADDR_IRQMASK: readdata <= 32'(irqmask);
        ADDR_EDGECAP: readdata <= 32'(edgecap);
        default:      readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_pio_in_edge.sv
// Directed bench: a 4-bit rising-edge PIO (table vectors + timing sequences) and a 32-bit any-edge PIO.
module tb_nios2_pio_in_edge;
  import nios2_pio_pkg::*;

`ifdef PIO_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif
  localparam int SETTLE = 6 + DB;
  localparam int NV     = 13;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_a;
  logic [31:0] rd_a;
  logic        irq_a;
  logic [31:0] in_b;
  logic [31:0] rd_b;
  logic        irq_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  nios2_pio_in_edge #(
    .WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISING),
    .IN_RESET_VAL(4'h0), .DEBOUNCE_CYCLES(16)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a)
  );

  nios2_pio_in_edge #(
    .WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY),
    .IN_RESET_VAL(32'h0), .DEBOUNCE_CYCLES(16)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(rd_b), .irq(irq_b)
  );

  typedef struct {
    logic [3:0]  din;
    logic        wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a;
    tick();
  endtask

  initial begin
    //           din    wr    wa            wd            ra            exp_rd        irq
    vecs[0]  = '{4'h0, 1'b0, ADDR_DATA,    32'h0,        ADDR_DATA,    32'h0,        1'b0};
    vecs[1]  = '{4'h5, 1'b0, ADDR_DATA,    32'h0,        ADDR_EDGECAP, 32'h5,        1'b0};
    vecs[2]  = '{4'h5, 1'b1, ADDR_EDGECAP, 32'h1,        ADDR_EDGECAP, 32'h4,        1'b0};
    vecs[3]  = '{4'h5, 1'b0, ADDR_DATA,    32'h0,        ADDR_DATA,    32'h5,        1'b0};
    vecs[4]  = '{4'h5, 1'b1, ADDR_IRQMASK, 32'h4,        ADDR_IRQMASK, 32'h4,        1'b1};
    vecs[5]  = '{4'h5, 1'b1, ADDR_EDGECAP, 32'h4,        ADDR_EDGECAP, 32'h0,        1'b0};
    vecs[6]  = '{4'h5, 1'b1, ADDR_DATA,    32'hF,        ADDR_IRQMASK, 32'h4,        1'b0};
    vecs[7]  = '{4'h5, 1'b1, ADDR_RSVD,    32'hF,        ADDR_RSVD,    32'h0,        1'b0};
    vecs[8]  = '{4'hF, 1'b0, ADDR_DATA,    32'h0,        ADDR_EDGECAP, 32'hA,        1'b0};
    vecs[9]  = '{4'hF, 1'b1, ADDR_IRQMASK, 32'hFFFFFFFF, ADDR_IRQMASK, 32'hF,        1'b1};
    vecs[10] = '{4'h0, 1'b0, ADDR_DATA,    32'h0,        ADDR_EDGECAP, 32'hA,        1'b1};
    vecs[11] = '{4'h0, 1'b1, ADDR_EDGECAP, 32'hFFFFFFFF, ADDR_EDGECAP, 32'h0,        1'b0};
    vecs[12] = '{4'h0, 1'b0, ADDR_DATA,    32'h0,        ADDR_DATA,    32'h0,        1'b0};

    reset_n    = 1'b0;
    address    = ADDR_DATA;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_a       = 4'hF;
    in_b       = 32'h0;

    // Reset with inputs already high: data appears after sync latency, no capture.
    repeat (3) tick();
    chk("reset readdata", rd_a, 32'h0);
    chk("reset irq", {31'b0, irq_a}, 32'h0);
    reset_n = 1'b1;
    repeat (2 + DB) tick();
    chk("data latency early", rd_a, 32'h0);
    tick();
    chk("data latency visible", rd_a, 32'hF);
    repeat (4) tick();
    bus_read(ADDR_EDGECAP);
    chk("reset no capture", rd_a, (DB > 0) ? 32'hF : 32'h0);
    chk("reset irq low", {31'b0, irq_a}, 32'h0);
    bus_write(ADDR_EDGECAP, 32'hF);
    in_a = 4'h0;
    repeat (SETTLE) tick();

    for (int i = 0; i < NV; i++) begin
      in_a = vecs[i].din;
      if (vecs[i].wr) bus_write(vecs[i].wa, vecs[i].wd);
      repeat (SETTLE) tick();
      bus_read(vecs[i].ra);
      chk($sformatf("vec%0d readdata", i), rd_a, vecs[i].exp_rd);
      chk($sformatf("vec%0d irq", i), {31'b0, irq_a}, {31'b0, vecs[i].exp_irq});
    end

    // irq follows edgecapture by one cycle on set and on clear.
    bus_write(ADDR_IRQMASK, 32'h4);
    address = ADDR_DATA;
    in_a    = 4'h4;
    repeat (3 + DB) tick();
    chk("irq before set", {31'b0, irq_a}, 32'h0);
    chk("data bit2 visible", rd_a, 32'h4);
    tick();
    chk("irq after set", {31'b0, irq_a}, 32'h1);
    bus_write(ADDR_EDGECAP, 32'h4);
    chk("irq at clear", {31'b0, irq_a}, 32'h1);
    tick();
    chk("irq after clear", {31'b0, irq_a}, 32'h0);

    // Edge and W1C of the same bit in one cycle: the capture survives.
    in_a = 4'h5;
    repeat (SETTLE) tick();
    in_a = 4'h4;
    repeat (SETTLE) tick();
    bus_read(ADDR_EDGECAP);
    chk("pre set bit0", rd_a, 32'h1);
    in_a = 4'h5;
    repeat (2 + DB) tick();
    bus_write(ADDR_EDGECAP, 32'h1);
    repeat (SETTLE) tick();
    bus_read(ADDR_EDGECAP);
    chk("set beats clear", rd_a, 32'h1);
    bus_write(ADDR_EDGECAP, 32'hF);

`ifdef PIO_DEBOUNCE_EN
    in_a = 4'h7;
    repeat (10) tick();
    in_a = 4'h5;
    repeat (SETTLE) tick();
    bus_read(ADDR_DATA);
    chk("short pulse data", rd_a, 32'h5);
    bus_read(ADDR_EDGECAP);
    chk("short pulse capture", rd_a, 32'h0);
    address = ADDR_DATA;
    in_a    = 4'h7;
    repeat (2 + DB) tick();
    chk("long pulse early", rd_a, 32'h5);
    tick();
    chk("long pulse data", rd_a, 32'h7);
    tick();
    in_a = 4'h5;
    repeat (SETTLE) tick();
    bus_read(ADDR_EDGECAP);
    chk("long pulse capture", rd_a, 32'h2);
    bus_write(ADDR_EDGECAP, 32'hF);
`endif

    // 32-bit any-edge instance.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (SETTLE) tick();
    in_b = 32'h8000_0000;
    repeat (SETTLE) tick();
    bus_read(ADDR_EDGECAP);
    chk("b rise bit31", rd_b, 32'h8000_0000);
    bus_write(ADDR_EDGECAP, 32'h8000_0000);
    bus_read(ADDR_EDGECAP);
    chk("b cleared", rd_b, 32'h0);
    in_b = 32'h0;
    repeat (SETTLE) tick();
    bus_read(ADDR_EDGECAP);
    chk("b fall bit31", rd_b, 32'h8000_0000);
    bus_read(ADDR_RSVD);
    chk("b reserved", rd_b, 32'h0);
    in_b = 32'h0001_0001;
    repeat (SETTLE) tick();
    bus_read(ADDR_DATA);
    chk("b data", rd_b, 32'h0001_0001);
    bus_write(ADDR_IRQMASK, 32'hFFFF_FFFF);
    bus_read(ADDR_IRQMASK);
    chk("b irqmask", rd_b, 32'hFFFF_FFFF);
    chk("b irq", {31'b0, irq_b}, 32'h1);

    // Mid-operation reset clears everything immediately; priming restarts.
    reset_n = 1'b0;
    #1;
    chk("b reset readdata", rd_b, 32'h0);
    chk("b reset irq", {31'b0, irq_b}, 32'h0);
    chk("a reset readdata", rd_a, 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (SETTLE) tick();
    bus_read(ADDR_IRQMASK);
    chk("b mask after reset", rd_b, 32'h0);
    bus_read(ADDR_EDGECAP);
    chk("b capture after reset", rd_b, (DB > 0) ? 32'h0001_0001 : 32'h0);
    bus_read(ADDR_DATA);
    chk("b data after reset", rd_b, 32'h0001_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
